// File: rtl/pio_input_debounce_irq_if.sv
// Avalon-MM slave bus bundle for the debounced input PIO.
// The master modport drives the bus and the slave modport returns readdata.
interface pio_input_debounce_irq_if;
  logic        chipselect;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output chipselect, address, write, writedata, input readdata);
  modport slave  (input chipselect, address, write, writedata, output readdata);
endinterface

// File: rtl/pio_input_debounce_irq.sv
// Input PIO: per-bit synchroniser and debouncer, edge capture with polarity select,
// interrupt mask, and a level irq to the interrupt controller.
module pio_input_debounce_irq #(
  parameter int unsigned WIDTH           = 3,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  pio_input_debounce_irq_if.slave bus,
  input  logic [WIDTH-1:0]        in_port,
  output logic                    irq
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_EDGESEL = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_w;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_sel_q, edge_sel_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic             wr_en;
  logic [WIDTH-1:0] wdata_w;
  logic [WIDTH-1:0] clr_w;
  logic [WIDTH-1:0] event_w;
  logic             unused_wdata;

  assign sync_w       = sync_q[SYNC_STAGES-1];
  assign wr_en        = bus.chipselect & bus.write;
  assign wdata_w      = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;

  // Next-state: debounce, edge capture, register writes and read mux
  always_comb begin
    deb_d      = deb_q;
    mask_d     = mask_q;
    edge_sel_d = edge_sel_q;
    clr_w      = '0;
    readdata_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_w[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync_w[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    // Polarity in force before this edge decides a transition on this edge
    event_w = (edge_sel_q & deb_d & ~deb_q) | (~edge_sel_q & ~deb_d & deb_q);

    if (wr_en) begin
      unique case (bus.address)
        ADDR_MASK:    mask_d     = wdata_w;
        ADDR_EDGESEL: edge_sel_d = wdata_w;
        ADDR_EDGECAP: clr_w      = wdata_w;
        default:      ;
      endcase
    end

    // A new event outranks a same-cycle clear
    edgecap_d = (edgecap_q & ~clr_w) | event_w;
    irq_d     = |(edgecap_d & mask_d);

    unique case (bus.address)
      ADDR_DATA:    readdata_d = 32'(deb_q);
      ADDR_MASK:    readdata_d = 32'(mask_q);
      ADDR_EDGESEL: readdata_d = 32'(edge_sel_q);
      ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < WIDTH; i++)       cnt_q[i]  <= '0;
      deb_q      <= '0;
      mask_q     <= '0;
      edge_sel_q <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync_q[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int i = 0; i < WIDTH; i++)       cnt_q[i]  <= cnt_d[i];
      deb_q      <= deb_d;
      mask_q     <= mask_d;
      edge_sel_q <= edge_sel_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_pio_input_debounce_irq.sv
// Directed bench for pio_input_debounce_irq with WIDTH=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_pio_input_debounce_irq;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned SYNC  = 2;
  localparam int unsigned DEB   = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] in_port;
  logic             irq;
  logic [31:0]      rd;
  int               n_tests = 0;
  int               n_fail  = 0;

  pio_input_debounce_irq_if bus();

  pio_input_debounce_irq #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write = 1'b0; bus.address = a;
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; in_port = '0;
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.address = 2'd0; bus.writedata = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_readdata", bus.readdata, 32'h0);
    check_eq("reset_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;

    bus_read(2'd0, rd); check_eq("rst_data", rd, 32'h0);
    bus_read(2'd1, rd); check_eq("rst_mask", rd, 32'h0);
    bus_read(2'd2, rd); check_eq("rst_edgesel", rd, 32'h0);
    bus_read(2'd3, rd); check_eq("rst_edgecap", rd, 32'h0);

    // 1: acceptance latency of a stable change, rising capture
    bus_write(2'd2, 32'h7);
    bus_read(2'd2, rd); check_eq("edgesel_rb", rd, 32'h7);
    @(negedge clk);
    bus.address = 2'd0; bus.chipselect = 1'b1; in_port = 3'b101;
    for (int k = 1; k <= SYNC + DEB; k++) begin
      @(negedge clk);
      check_eq($sformatf("t1_data_early%0d", k), bus.readdata, 32'h0);
    end
    @(negedge clk);
    check_eq("t1_data_accept", bus.readdata, 32'h5);
    bus.chipselect = 1'b0;
    bus_read(2'd3, rd); check_eq("t1_edgecap", rd, 32'h5);
    check_eq("t1_irq_masked", 32'(irq), 32'h0);
    bus_write(2'd0, 32'h0);
    bus_read(2'd0, rd); check_eq("t1_data_ro", rd, 32'h5);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, rd); check_eq("t1_mask_hi_bits", rd, 32'h7);
    bus_write(2'd1, 32'h0);
    bus_write(2'd3, 32'h7);
    bus_read(2'd3, rd); check_eq("t1_edgecap_clr", rd, 32'h0);

    // 2: three-cycle glitch on bit1 is rejected
    @(negedge clk); in_port = 3'b111;
    repeat (3) @(negedge clk);
    in_port = 3'b101;
    settle();
    bus_read(2'd0, rd); check_eq("t2_data", rd, 32'h5);
    bus_read(2'd3, rd); check_eq("t2_edgecap", rd, 32'h0);
    check_eq("t2_irq", 32'(irq), 32'h0);

    // 3: interrupt path and W1C
    bus_write(2'd1, 32'h2);
    @(negedge clk); in_port = 3'b111;
    settle();
    bus_read(2'd3, rd); check_eq("t3_edgecap", rd, 32'h2);
    check_eq("t3_irq_set", 32'(irq), 32'h1);
    bus_write(2'd3, 32'h1);
    check_eq("t3_irq_w1c_other", 32'(irq), 32'h1);
    bus_read(2'd3, rd); check_eq("t3_edgecap_keep", rd, 32'h2);
    bus_write(2'd3, 32'h2);
    check_eq("t3_irq_clr", 32'(irq), 32'h0);
    bus_read(2'd3, rd); check_eq("t3_edgecap_clr", rd, 32'h0);

    // 4: falling polarity on bit0
    bus_write(2'd2, 32'h0);
    @(negedge clk); in_port = 3'b110;
    settle();
    bus_read(2'd3, rd); check_eq("t4_fall1", rd, 32'h1);
    bus_write(2'd3, 32'h7);
    @(negedge clk); in_port = 3'b111;
    settle();
    bus_read(2'd0, rd); check_eq("t4_data_rise", rd, 32'h7);
    bus_read(2'd3, rd); check_eq("t4_no_rise", rd, 32'h0);
    @(negedge clk); in_port = 3'b110;
    settle();
    bus_read(2'd3, rd); check_eq("t4_fall2", rd, 32'h1);
    check_eq("t4_irq_unmasked_bit", 32'(irq), 32'h0);

    // 5: clear of bit2 lands on the same edge deb[2] rises
    bus_write(2'd2, 32'h4);
    @(negedge clk); in_port = 3'b010;
    settle();
    bus_write(2'd3, 32'h7);
    bus_read(2'd3, rd); check_eq("t5_pre_clr", rd, 32'h0);
    @(negedge clk); in_port = 3'b110;
    repeat (SYNC + DEB - 1) @(negedge clk);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 2'd3; bus.writedata = 32'h4;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write = 1'b0;
    bus_read(2'd3, rd); check_eq("t5_set_wins", rd, 32'h4);
    bus_read(2'd0, rd); check_eq("t5_data", rd, 32'h6);

    // 6: reset in the middle of a debounce count
    bus_write(2'd1, 32'h7);
    check_eq("t6_irq_before", 32'(irq), 32'h1);
    @(negedge clk); in_port = 3'b111;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_readdata", bus.readdata, 32'h0);
    check_eq("t6_rst_irq", 32'(irq), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1; bus.address = 2'd0; bus.chipselect = 1'b1;
    for (int k = 1; k <= SYNC + DEB; k++) begin
      @(negedge clk);
      check_eq($sformatf("t6_data_early%0d", k), bus.readdata, 32'h0);
    end
    @(negedge clk);
    check_eq("t6_data_accept", bus.readdata, 32'h7);
    bus.chipselect = 1'b0;
    bus_read(2'd1, rd); check_eq("t6_mask", rd, 32'h0);
    bus_read(2'd2, rd); check_eq("t6_edgesel", rd, 32'h0);
    bus_read(2'd3, rd); check_eq("t6_edgecap", rd, 32'h0);
    check_eq("t6_irq", 32'(irq), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
